alu_result_display: RTL and testbench

Downstream display stage for the ALU. It watches the ALU's 8-bit `out_put` result and `carry_flag`. When the result changes, it converts the value to three BCD digits with a sequential shift-add-3 (double-dabble) converter. It then time-multiplexes the digits and a carry indicator onto a 4-digit active-low seven-segment display on the board.

---
 rtl/alu_result_display.sv | 170 +++++++++++++++++
 tb/tb_alu_result_display.sv | 196 +++++++++++++++++++
 2 files changed

// File: rtl/alu_result_display.sv
// ALU result display stage: converts the 8-bit result to BCD with a sequential
// double-dabble converter and scans three digits plus a carry indicator onto a 4-digit display.
module alu_result_display #(
    parameter int unsigned REFRESH_DIV = 50000
) (
    input  logic       clk,
    input  logic       reset_n,
    input  logic [7:0] out_put,
    input  logic       carry_flag,
    output logic [6:0] seg,
    output logic [3:0] an,
    output logic       busy
);

    localparam int unsigned CntW = $clog2(REFRESH_DIV);
    localparam logic [CntW-1:0] CntMax = CntW'(REFRESH_DIV - 1);

    localparam logic [6:0] SegBlank = 7'h7F;
    localparam logic [6:0] SegC     = 7'h46;

    typedef enum logic [1:0] {StIdle, StShift, StDone} state_e;

    state_e          state_q, state_d;
    logic [8:0]      last_value_q, last_value_d;
    logic [19:0]     shift_q, shift_d;
    logic [2:0]      iter_q, iter_d;
    logic [3:0]      hund_q, hund_d;
    logic [3:0]      tens_q, tens_d;
    logic [3:0]      ones_q, ones_d;
    logic            carry_disp_q, carry_disp_d;
    logic [CntW-1:0] refresh_cnt_q, refresh_cnt_d;
    logic [1:0]      digit_idx_q, digit_idx_d;
    logic [3:0]      an_q, an_d;
    logic [6:0]      seg_q, seg_d;

    logic [8:0]  in_value;
    logic [19:0] adj;

    assign in_value = {carry_flag, out_put};

    function automatic logic [6:0] seg_code(input logic [3:0] d);
        logic [6:0] code;
        case (d)
            4'd0:    code = 7'h40;
            4'd1:    code = 7'h79;
            4'd2:    code = 7'h24;
            4'd3:    code = 7'h30;
            4'd4:    code = 7'h19;
            4'd5:    code = 7'h12;
            4'd6:    code = 7'h02;
            4'd7:    code = 7'h78;
            4'd8:    code = 7'h00;
            4'd9:    code = 7'h10;
            default: code = SegBlank;
        endcase
        return code;
    endfunction

    // Converter: shift_q holds {hund, tens, ones, binary}; BCD lands in [19:8] after 8 shifts.
    always_comb begin
        state_d      = state_q;
        last_value_d = last_value_q;
        shift_d      = shift_q;
        iter_d       = iter_q;
        hund_d       = hund_q;
        tens_d       = tens_q;
        ones_d       = ones_q;
        carry_disp_d = carry_disp_q;
        adj          = shift_q;

        unique case (state_q)
            StIdle: begin
                if (in_value != last_value_q) begin
                    last_value_d = in_value;
                    shift_d      = {12'd0, out_put};
                    iter_d       = 3'd0;
                    state_d      = StShift;
                end
            end
            StShift: begin
                if (adj[19:16] >= 4'd5) adj[19:16] = adj[19:16] + 4'd3;
                if (adj[15:12] >= 4'd5) adj[15:12] = adj[15:12] + 4'd3;
                if (adj[11:8]  >= 4'd5) adj[11:8]  = adj[11:8]  + 4'd3;
                shift_d = {adj[18:0], 1'b0};
                iter_d  = iter_q + 3'd1;
                if (iter_q == 3'd7) begin
                    state_d = StDone;
                end
            end
            StDone: begin
                hund_d       = shift_q[19:16];
                tens_d       = shift_q[15:12];
                ones_d       = shift_q[11:8];
                carry_disp_d = last_value_q[8];
                state_d      = StIdle;
            end
            default: state_d = StIdle;
        endcase
    end

    // Scan timer and registered digit/segment drive.
    always_comb begin
        refresh_cnt_d = refresh_cnt_q + CntW'(1);
        digit_idx_d   = digit_idx_q;
        if (refresh_cnt_q == CntMax) begin
            refresh_cnt_d = '0;
            digit_idx_d   = digit_idx_q + 2'd1;
        end

        an_d  = 4'b1110;
        seg_d = seg_code(ones_q);
        unique case (digit_idx_q)
            2'd0: begin
                an_d  = 4'b1110;
                seg_d = seg_code(ones_q);
            end
            2'd1: begin
                an_d  = 4'b1101;
                seg_d = (hund_q == 4'd0 && tens_q == 4'd0) ? SegBlank : seg_code(tens_q);
            end
            2'd2: begin
                an_d  = 4'b1011;
                seg_d = (hund_q == 4'd0) ? SegBlank : seg_code(hund_q);
            end
            2'd3: begin
                an_d  = 4'b0111;
                seg_d = carry_disp_q ? SegC : SegBlank;
            end
            default: begin
                an_d  = 4'b1111;
                seg_d = SegBlank;
            end
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q       <= StIdle;
            last_value_q  <= '0;
            shift_q       <= '0;
            iter_q        <= '0;
            hund_q        <= '0;
            tens_q        <= '0;
            ones_q        <= '0;
            carry_disp_q  <= 1'b0;
            refresh_cnt_q <= '0;
            digit_idx_q   <= '0;
            an_q          <= 4'hF;
            seg_q         <= SegBlank;
        end else begin
            state_q       <= state_d;
            last_value_q  <= last_value_d;
            shift_q       <= shift_d;
            iter_q        <= iter_d;
            hund_q        <= hund_d;
            tens_q        <= tens_d;
            ones_q        <= ones_d;
            carry_disp_q  <= carry_disp_d;
            refresh_cnt_q <= refresh_cnt_d;
            digit_idx_q   <= digit_idx_d;
            an_q          <= an_d;
            seg_q         <= seg_d;
        end
    end

    assign an   = an_q;
    assign seg  = seg_q;
    assign busy = (state_q != StIdle);

endmodule

// File: tb/tb_alu_result_display.sv
// Directed bench for alu_result_display: expected digit/segment pairs are queued per value
// and popped as the scan reaches each digit.
module tb_alu_result_display;

    logic       clk = 1'b0;
    logic       reset_n = 1'b0;
    logic [7:0] out_put = 8'd0;
    logic       carry_flag = 1'b0;
    logic [6:0] seg;
    logic [3:0] an;
    logic       busy;

    int n_assert = 0;
    int n_fail   = 0;

    typedef struct {
        logic [3:0]  an;
        logic [6:0]  seg;
        int unsigned value;
    } exp_t;

    exp_t sb_q[$];

    alu_result_display #(.REFRESH_DIV(4)) dut (
        .clk        (clk),
        .reset_n    (reset_n),
        .out_put    (out_put),
        .carry_flag (carry_flag),
        .seg        (seg),
        .an         (an),
        .busy       (busy)
    );

    always #5 clk = ~clk;

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    function automatic logic [6:0] dig_code(input int unsigned d);
        logic [6:0] tab [10];
        tab = '{7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h78, 7'h00, 7'h10};
        return tab[d];
    endfunction

    // Reference model of what a given digit enable should show for a value.
    function automatic logic [6:0] exp_seg(input logic [3:0] a, input int unsigned v,
                                           input logic c);
        int unsigned h, t, o;
        h = v / 100;
        t = (v / 10) % 10;
        o = v % 10;
        case (a)
            4'b1110: return dig_code(o);
            4'b1101: return (h == 0 && t == 0) ? 7'h7F : dig_code(t);
            4'b1011: return (h == 0) ? 7'h7F : dig_code(h);
            4'b0111: return c ? 7'h46 : 7'h7F;
            default: return 7'h7F;
        endcase
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic push_display(input int unsigned v, input logic c);
        logic [3:0] ans [4];
        ans = '{4'b1110, 4'b1101, 4'b1011, 4'b0111};
        foreach (ans[i]) sb_q.push_back('{an: ans[i], seg: exp_seg(ans[i], v, c), value: v});
    endtask

    task automatic check_display();
        exp_t e;
        int   k;
        while (sb_q.size() > 0) begin
            e = sb_q.pop_front();
            k = 0;
            while (an !== e.an && k < 40) begin
                tick();
                k++;
            end
            chk($sformatf("an_%0d", e.value), {28'd0, an}, {28'd0, e.an});
            chk($sformatf("seg_%0d_an%b", e.value, e.an), {25'd0, seg}, {25'd0, e.seg});
        end
    endtask

    // Applies a value, checks the 9-cycle busy window, then the scanned display.
    task automatic convert(input logic [7:0] v, input logic c);
        int cnt;
        out_put    = v;
        carry_flag = c;
        tick();
        cnt = 0;
        while (busy && cnt < 40) begin
            cnt++;
            tick();
        end
        chk($sformatf("busy_len_%0d", v), cnt, 9);
        tick();
        push_display(int'(v), c);
        check_display();
    endtask

    initial begin
        int cnt;

        // Reset held for 3 cycles
        reset_n = 1'b0;
        tick(); tick(); tick();
        chk("rst_an", {28'd0, an}, 32'hF);
        chk("rst_seg", {25'd0, seg}, 32'h7F);
        chk("rst_busy", {31'd0, busy}, 0);
        reset_n = 1'b1;
        tick();
        chk("post_rst_an", {28'd0, an}, 32'hE);
        chk("post_rst_seg", {25'd0, seg}, 32'h40);
        tick(); tick(); tick();
        chk("scan_hold_an", {28'd0, an}, 32'hE);
        tick();
        chk("scan_adv_an", {28'd0, an}, 32'hD);
        chk("zero_no_conv", {31'd0, busy}, 0);

        // Full scale, leading-zero blanking, embedded zeros
        convert(8'd255, 1'b1);
        convert(8'd7, 1'b0);
        convert(8'd100, 1'b0);

        // Change during conversion
        out_put = 8'd12;
        tick();
        chk("chg_busy1", {31'd0, busy}, 1);
        tick(); tick();
        chk("chg_busy3", {31'd0, busy}, 1);
        out_put = 8'd34;
        cnt = 3;
        tick();
        while (busy && cnt < 40) begin
            cnt++;
            tick();
        end
        chk("chg_busy_len", cnt, 9);
        tick();
        chk("chg_rebusy", {31'd0, busy}, 1);
        cnt = 0;
        while (busy && cnt < 40) begin
            chk($sformatf("chg_mid_seg_an%b", an), {25'd0, seg}, {25'd0, exp_seg(an, 12, 1'b0)});
            cnt++;
            tick();
        end
        chk("chg_busy_end", {31'd0, busy}, 0);
        tick();
        push_display(34, 1'b0);
        check_display();

        // Reset mid-conversion
        out_put = 8'd200;
        tick(); tick(); tick(); tick();
        chk("rmid_busy4", {31'd0, busy}, 1);
        reset_n = 1'b0;
        #1;
        chk("rmid_busy", {31'd0, busy}, 0);
        chk("rmid_an", {28'd0, an}, 32'hF);
        chk("rmid_seg", {25'd0, seg}, 32'h7F);
        tick(); tick();
        reset_n = 1'b1;
        tick();
        chk("rmid_rel_an", {28'd0, an}, 32'hE);
        chk("rmid_rel_seg", {25'd0, seg}, 32'h40);
        chk("rmid_rel_busy", {31'd0, busy}, 1);
        cnt = 1;
        tick();
        while (busy && cnt < 40) begin
            cnt++;
            tick();
        end
        chk("rmid_busy_len", cnt, 9);
        tick();
        push_display(200, 1'b0);
        check_display();

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
